ps2_host_tx: RTL
================

# ps2_host_tx

Host-to-device PS/2 transmitter for the minesweeper keyboard path. It sends one command byte (LED set 0xED, reset 0xFF, enable 0xF4, …) to the keyboard through open-drain control of PS2_CLK and PS2_DAT. It runs the full request-to-send sequence: inhibit, start bit, 8 data bits LSB first, odd parity, stop, then device acknowledge. It sits beside the existing scancode receiver and shares the same pins. The receiver must ignore line activity while `busy` is high.

## Interface
- `INHIBIT_CYCLES`, default 6000: clock-low inhibit duration in `clock` cycles (120 µs at 50 MHz).
- `REQ_CYCLES`, default 4: cycles data is held low before the clock is released.
- `TIMEOUT_CYCLES`, default 750000: maximum gap between device clock falling edges, and maximum wait for bus idle (15 ms).

Ports:
- `clock`  in  1: system clock (50 MHz).
- `reset`  in  1: synchronous, active-low.
- `send_valid`  in  1: request to transmit `send_data`.
- `send_data`  in  8: command byte.
- `send_ready`  out  1: high only in IDLE. A byte is accepted when `send_valid & send_ready`.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when the device has acked and the bus is idle.
- `error`  out  1: one-cycle pulse on NACK or timeout.
- `ps2_clk_in`  in  1: raw PS2_CLK pin level (asynchronous).
- `ps2_dat_in`  in  1: raw PS2_DAT pin level (asynchronous).
- `ps2_clk_oe`  out  1: 1 = drive PS2_CLK low; 0 = release.
- `ps2_dat_oe`  out  1: 1 = drive PS2_DAT low; 0 = release.

## Operation
- **Input conditioning.** Pin inputs pass through a 2-FF synchronizer. A falling edge `fall` is synced-previous 1 and synced-current 0. `fall` is one cycle wide.
- **Reset values.** State IDLE, `ps2_clk_oe`=0, `ps2_dat_oe`=0, `send_ready`=1, `busy`=0, `done`=0, `error`=0. All counters and the shift register are 0.
- **IDLE.** On accept:
  - latch the frame `{1'b1 stop, parity, send_data}`, where parity = ~^send_data;
  - clear the bit count and the cycle counter;
  - go to INHIBIT.
- **INHIBIT.** `clk_oe`=1, `dat_oe`=0 for exactly INHIBIT_CYCLES cycles, then go to REQ.
- **REQ.** `clk_oe`=1, `dat_oe`=1 (start bit 0) for REQ_CYCLES cycles. Then `clk_oe`=0 and go to SHIFT.
- **SHIFT.**
  - On each `fall`, present the next frame bit: `dat_oe` = ~bit. Order is data[0]..data[7], parity, stop.
  - The bit count runs 0..9.
  - On the `fall` that presents the stop bit (count 9), `dat_oe`=0; go to ACK.
- **ACK.** On the next `fall`, sample synced data:
  - 0 → go to WAIT_IDLE;
  - 1 → NACK: pulse `error`, go to IDLE.
- **WAIT_IDLE.** When synced clk=1 and dat=1, pulse `done` and go to IDLE.
- **Timeout.**
  - The cycle counter clears on every `fall` and on every state entry.
  - In SHIFT, ACK or WAIT_IDLE, reaching TIMEOUT_CYCLES → release both lines, pulse `error`, go to IDLE.
  - The counter width is $clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1). It saturates and never wraps.
- **Simultaneous events.**
  - `send_valid` outside IDLE is ignored and not queued.
  - If timeout and `fall` occur in the same cycle, `fall` wins.
  - `done` and `error` are mutually exclusive.
- **Reset mid-operation.** Both `oe` outputs are 0 on the cycle after reset is sampled low. No `done` or `error` pulse is generated.

## Timing
- Accept edge → `clk_oe`=1 on the next cycle (1-cycle registered latency).
- All outputs are registered. No combinational path from pins to `oe`.
- `dat_oe` changes within 3 cycles of the pin falling edge (2 sync + 1 register), which is well inside the device's ~30 µs clock-low phase.
- `done` asserts 1 cycle after both synced lines are seen high in WAIT_IDLE. `send_ready` rises in the same cycle as `done` or `error`.
- Minimum transaction length: INHIBIT_CYCLES + REQ_CYCLES + 1, plus 11 device clocks.

## Structure
- Shared package `ps2_pkg` holds:
  - the state enum (IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE);
  - command constants CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4;
  - device response constants RSP_ACK=8'hFA, RSP_BAT_OK=8'hAA.
- Sub-module `ps2_line_sync` (2-FF sync plus falling-edge detect for clk and dat). The receiver reuses it.

## Test plan
Use INHIBIT_CYCLES=20, REQ_CYCLES=4, TIMEOUT_CYCLES=200. The bench device model clocks at a 40-cycle period and samples data on rising edges.
- Send 0xED, device acks:
  - `clk_oe` high for 20 cycles, then `dat_oe` high for 4 cycles with clock still held;
  - device captures start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - `done` pulses once, `error` stays 0, `send_ready` returns to 1.
- Send 0x01 → parity bit 0. Send 0xFF → parity bit 1. Both complete with `done`.
- NACK: device leaves data high at ACK → one `error` pulse, no `done`, both `oe`=0, state IDLE.
- Timeout: device never clocks after REQ → `error` 200 cycles after clock release, lines released.
- Busy rejection and reset:
  - a second `send_valid` with 0x55 mid-SHIFT is ignored, and only 0xED frames appear;
  - reset asserted mid-SHIFT → `oe` both 0 the next cycle, `send_ready`=1, no pulses.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller states, keyboard commands and
// device responses used by the host transmitter and scancode receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;

  // Shift order is LSB first: data[0..7], odd parity, stop.
  function automatic logic [9:0] make_frame(
    input logic [7:0] data
  );
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins with
// single-cycle falling-edge strobes on the synchronized levels.
module ps2_line_sync (
  input  logic clock,
  input  logic reset,
  input  logic clk_raw,
  input  logic dat_raw,
  output logic clk_level,
  output logic dat_level,
  output logic clk_fall,
  output logic dat_fall
);

  logic [1:0] clk_ff;
  logic [1:0] dat_ff;
  logic       clk_prev;
  logic       dat_prev;

  // Reset to the idle-bus level so no edge is reported on release.
  always_ff @(posedge clock) begin
    if (!reset) begin
      clk_ff   <= 2'b11;
      dat_ff   <= 2'b11;
      clk_prev <= 1'b1;
      dat_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], clk_raw};
      dat_ff   <= {dat_ff[0], dat_raw};
      clk_prev <= clk_ff[1];
      dat_prev <= dat_ff[1];
    end
  end

  assign clk_level = clk_ff[1];
  assign dat_level = dat_ff[1];
  assign clk_fall  = clk_prev & ~clk_ff[1];
  assign dat_fall  = dat_prev & ~dat_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send,
// 11-bit frame clocked by the device, then ack and bus-idle wait.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int REQ_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send_valid,
  input  logic [7:0] send_data,
  output logic       send_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int MAX_CYCLES =
    (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
    INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] REQ_LAST = CW'(REQ_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [9:0]    frame;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] cnt;

  logic clk_level;
  logic dat_level;
  logic clk_fall;
  logic unused_dat_fall;

  ps2_line_sync u_sync (
    .clock     (clock),
    .reset     (reset),
    .clk_raw   (ps2_clk_in),
    .dat_raw   (ps2_dat_in),
    .clk_level (clk_level),
    .dat_level (dat_level),
    .clk_fall  (clk_fall),
    .dat_fall  (unused_dat_fall)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      frame      <= '0;
      bit_cnt    <= '0;
      cnt        <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      send_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (state != IDLE && cnt != '1)
        cnt <= cnt + 1'b1;

      unique case (state)
        IDLE: begin
          if (send_valid && send_ready) begin
            frame      <= make_frame(send_data);
            bit_cnt    <= '0;
            cnt        <= '0;
            ps2_clk_oe <= 1'b1;
            ps2_dat_oe <= 1'b0;
            send_ready <= 1'b0;
            busy       <= 1'b1;
            state      <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (cnt == INH_LAST) begin
            cnt        <= '0;
            ps2_dat_oe <= 1'b1;
            state      <= REQ;
          end
        end

        REQ: begin
          if (cnt == REQ_LAST) begin
            cnt        <= '0;
            ps2_clk_oe <= 1'b0;
            state      <= SHIFT;
          end
        end

        // A device edge outranks a timeout landing in the same cycle.
        SHIFT: begin
          if (clk_fall) begin
            cnt        <= '0;
            ps2_dat_oe <= ~frame[bit_cnt];
            if (bit_cnt == 4'd9)
              state <= ACK;
            else
              bit_cnt <= bit_cnt + 1'b1;
          end else if (cnt == TO_LAST) begin
            cnt        <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            error      <= 1'b1;
            send_ready <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end

        ACK: begin
          if (clk_fall) begin
            cnt <= '0;
            if (!dat_level) begin
              state <= WAIT_IDLE;
            end else begin
              error      <= 1'b1;
              send_ready <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end else if (cnt == TO_LAST) begin
            cnt        <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            error      <= 1'b1;
            send_ready <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end

        WAIT_IDLE: begin
          if (clk_level && dat_level) begin
            cnt        <= '0;
            done       <= 1'b1;
            send_ready <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (cnt == TO_LAST) begin
            cnt        <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            error      <= 1'b1;
            send_ready <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end

        default: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          send_ready <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
